// File: rtl/door_lock_ctrl.sv
// Keypad code lock: CODE_LEN-digit entry check, idle timeout, failed-attempt lockout
// and in-field code reprogramming while the door is open.
module door_lock_ctrl #(
  parameter int unsigned                       DIGIT_W      = 4,
  parameter int unsigned                       CODE_LEN     = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0]       DEFAULT_CODE = 16'h1324,
  parameter int unsigned                       TIMEOUT_CYC  = 10,
  parameter int unsigned                       OPEN_CYC     = 32,
  parameter int unsigned                       ERR_CYC      = 4,
  parameter int unsigned                       MAX_FAILS    = 3,
  parameter int unsigned                       LOCKOUT_CYC  = 64,
  localparam int unsigned                      FAIL_W       = $clog2(MAX_FAILS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key,
  input  logic               prog_req,
  output logic               unlock,
  output logic               green,
  output logic               red,
  output logic               locked_out,
  output logic               timeout,
  output logic [FAIL_W-1:0]  fail_cnt
);

  localparam int unsigned CODE_W  = DIGIT_W * CODE_LEN;
  localparam int unsigned MAX_A   = (TIMEOUT_CYC > OPEN_CYC) ? TIMEOUT_CYC : OPEN_CYC;
  localparam int unsigned MAX_B   = (ERR_CYC > LOCKOUT_CYC) ? ERR_CYC : LOCKOUT_CYC;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  typedef enum logic [2:0] {IDLE, ENTRY, OPEN, PROG, ERR, LOCKOUT} state_t;

  state_t             state, state_nxt;
  logic [CODE_W-1:0]  code, code_nxt, shadow, shadow_nxt, prog_word;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt, sel;
  logic               mism, mism_nxt, miss, last, timeout_nxt;
  logic [FAIL_W-1:0]  fail_nxt;
  logic [DIGIT_W-1:0] digit;

  // Digit under comparison; IDLE always compares against the first digit.
  always_comb begin
    sel   = (state == ENTRY) ? idx : '0;
    digit = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++)
      if (sel == IDX_W'(i)) digit = code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
  end

  assign miss      = ((state == ENTRY) && mism) || (key != digit);
  assign last      = (state == ENTRY) ? (idx == IDX_W'(CODE_LEN - 1)) : (CODE_LEN == 1);
  assign prog_word = (shadow << DIGIT_W) | CODE_W'(key);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    mism_nxt    = mism;
    fail_nxt    = fail_cnt;
    code_nxt    = code;
    shadow_nxt  = shadow;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (key_valid) begin
          cnt_nxt = '0;
          if (last) begin
            idx_nxt  = '0;
            mism_nxt = 1'b0;
            if (!miss) begin
              state_nxt = OPEN;
              fail_nxt  = '0;
            end else if (fail_cnt >= FAIL_W'(MAX_FAILS - 1)) begin
              state_nxt = LOCKOUT;
              fail_nxt  = FAIL_W'(MAX_FAILS);
            end else begin
              state_nxt = ERR;
              fail_nxt  = fail_cnt + 1'b1;
            end
          end else begin
            state_nxt = ENTRY;
            idx_nxt   = sel + 1'b1;
            mism_nxt  = miss;
          end
        end else if (state == ENTRY) begin
          if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            idx_nxt     = '0;
            mism_nxt    = 1'b0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      OPEN: begin
        if (prog_req) begin
          state_nxt = PROG;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (cnt == CNT_W'(OPEN_CYC - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PROG: begin
        if (key_valid) begin
          cnt_nxt    = '0;
          shadow_nxt = prog_word;
          if (idx == IDX_W'(CODE_LEN - 1)) begin
            code_nxt  = prog_word;
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          idx_nxt     = '0;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ERR: begin
        if (cnt == CNT_W'(ERR_CYC - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOCKOUT: begin
        if (cnt == CNT_W'(LOCKOUT_CYC - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          fail_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      code       <= DEFAULT_CODE;
      shadow     <= '0;
      cnt        <= '0;
      idx        <= '0;
      mism       <= 1'b0;
      fail_cnt   <= '0;
      unlock     <= 1'b0;
      green      <= 1'b0;
      red        <= 1'b0;
      locked_out <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      shadow     <= shadow_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      mism       <= mism_nxt;
      fail_cnt   <= fail_nxt;
      unlock     <= (state_nxt == OPEN);
      green      <= (state_nxt == OPEN) || (state_nxt == PROG);
      red        <= (state_nxt == ERR) || (state_nxt == LOCKOUT);
      locked_out <= (state_nxt == LOCKOUT);
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Bench for door_lock_ctrl: directed scenarios plus random keypad traffic checked
// every cycle against a queue-based model of the lock's rules.
module tb_door_lock_ctrl;
  localparam int DIGIT_W     = 4;
  localparam int CODE_LEN    = 4;
  localparam int TIMEOUT_CYC = 10;
  localparam int OPEN_CYC    = 32;
  localparam int ERR_CYC     = 4;
  localparam int MAX_FAILS   = 3;
  localparam int LOCKOUT_CYC = 64;
  localparam logic [15:0] DEFAULT_CODE = 16'h1324;
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key = '0;
  logic          prog_req = 1'b0;
  logic          unlock, green, red, locked_out, timeout;
  logic [FW-1:0] fail_cnt;

  door_lock_ctrl #(
    .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEFAULT_CODE),
    .TIMEOUT_CYC(TIMEOUT_CYC), .OPEN_CYC(OPEN_CYC), .ERR_CYC(ERR_CYC),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key(key),
    .prog_req(prog_req), .unlock(unlock), .green(green), .red(red),
    .locked_out(locked_out), .timeout(timeout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_ENTRY, M_OPEN, M_PROG, M_ERR, M_LOCK} mode_t;
  mode_t m;
  int    mcode[CODE_LEN];
  int    entered[$];
  int    newcode[$];
  int    since, left, fails;
  bit    to;
  int    n_cmp = 0;
  int    n_bad = 0;

  function void mreset();
    m = M_IDLE;
    for (int i = 0; i < CODE_LEN; i++)
      mcode[i] = int'((DEFAULT_CODE >> (DIGIT_W * (CODE_LEN - 1 - i))) & 16'hF);
    entered.delete();
    newcode.delete();
    since = 0; left = 0; fails = 0; to = 0;
  endfunction

  function void judge();
    bit ok;
    ok = 1;
    foreach (entered[i]) if (entered[i] != mcode[i]) ok = 0;
    entered.delete();
    if (ok) begin
      m = M_OPEN; left = OPEN_CYC; fails = 0;
    end else begin
      if (fails < MAX_FAILS) fails++;
      if (fails == MAX_FAILS) begin m = M_LOCK; left = LOCKOUT_CYC; end
      else begin m = M_ERR; left = ERR_CYC; end
    end
  endfunction

  function void mstep(input bit kv, input int k, input bit pr);
    to = 0;
    case (m)
      M_IDLE, M_ENTRY: begin
        if (kv) begin
          entered.push_back(k);
          since = 0;
          if (entered.size() == CODE_LEN) judge();
          else m = M_ENTRY;
        end else if (m == M_ENTRY) begin
          since++;
          if (since == TIMEOUT_CYC) begin to = 1; entered.delete(); m = M_IDLE; end
        end
      end
      M_OPEN: begin
        if (pr) begin m = M_PROG; newcode.delete(); since = 0; end
        else begin left--; if (left == 0) m = M_IDLE; end
      end
      M_PROG: begin
        if (kv) begin
          newcode.push_back(k);
          since = 0;
          if (newcode.size() == CODE_LEN) begin
            foreach (newcode[i]) mcode[i] = newcode[i];
            m = M_IDLE;
          end
        end else begin
          since++;
          if (since == TIMEOUT_CYC) begin to = 1; m = M_IDLE; end
        end
      end
      M_ERR: begin left--; if (left == 0) m = M_IDLE; end
      M_LOCK: begin left--; if (left == 0) begin m = M_IDLE; fails = 0; end end
      default: m = M_IDLE;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mreset();
    else mstep(key_valid, int'(key), prog_req);
  end

  always @(negedge clk) begin
    logic [FW+4:0] got, exp;
    got = {unlock, green, red, locked_out, timeout, fail_cnt};
    exp = {m == M_OPEN, (m == M_OPEN) || (m == M_PROG), (m == M_ERR) || (m == M_LOCK),
           m == M_LOCK, to, FW'(fails)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t {unlock,green,red,locked_out,timeout,fail_cnt} got=%b want=%b",
               $time, got, exp);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit kv, input int k, input bit pr);
    key_valid = kv;
    key       = 4'(k);
    prog_req  = pr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic keys(input int a, input int b, input int c, input int d);
    step(1, a, 0); step(1, b, 0); step(1, c, 0); step(1, d, 0);
    key_valid = 0;
  endtask

  initial begin
    int r, pos, k;
    bit kv, pr;
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_unlock", unlock, 0);
    chk("rst_red", red, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    reset_n = 1;
    idle(2);

    keys(1, 3, 2, 4);
    chk("open_unlock", unlock, 1);
    chk("open_green", green, 1);
    chk("open_fail_cnt", fail_cnt, 0);
    idle(31);
    chk("open_last_cycle", unlock, 1);
    idle(1);
    chk("open_closed", unlock, 0);

    for (int i = 1; i <= 2; i++) begin
      keys(1, 2, 3, 4);
      chk("err_red", red, 1);
      chk("err_fail_cnt", fail_cnt, i);
      idle(ERR_CYC);
      chk("err_over", red, 0);
    end
    keys(1, 2, 3, 4);
    chk("lock_locked_out", locked_out, 1);
    chk("lock_fail_cnt", fail_cnt, 3);
    keys(1, 3, 2, 4);
    idle(59);
    chk("lock_still", locked_out, 1);
    chk("lock_unlock_ignored", unlock, 0);
    idle(1);
    chk("lock_exit", locked_out, 0);
    chk("lock_exit_fail_cnt", fail_cnt, 0);
    keys(1, 3, 2, 4);
    chk("after_lock_open", unlock, 1);
    idle(OPEN_CYC);

    step(1, 1, 0); step(1, 3, 0);
    idle(9);
    chk("tmo_not_yet", timeout, 0);
    idle(1);
    chk("tmo_pulse", timeout, 1);
    chk("tmo_fail_cnt", fail_cnt, 0);
    idle(1);
    chk("tmo_one_cycle", timeout, 0);
    keys(1, 3, 2, 4);
    chk("tmo_then_open", unlock, 1);

    step(0, 0, 1);
    chk("prog_green", green, 1);
    chk("prog_unlock_drop", unlock, 0);
    step(1, 5, 0); step(1, 5, 0);
    idle(TIMEOUT_CYC);
    chk("prog_tmo_pulse", timeout, 1);
    keys(1, 3, 2, 4);
    chk("prog_tmo_code_kept", unlock, 1);

    step(1, 7, 1);
    keys(9, 8, 7, 6);
    chk("prog_done_green", green, 0);
    keys(1, 3, 2, 4);
    chk("old_code_fails", red, 1);
    chk("old_code_fail_cnt", fail_cnt, 1);
    idle(ERR_CYC);
    keys(9, 8, 7, 6);
    chk("new_code_opens", unlock, 1);
    chk("new_code_fail_cnt", fail_cnt, 0);

    idle(3);
    #3 reset_n = 0;
    #1 chk("rst_open_unlock", unlock, 0);
    chk("rst_open_green", green, 0);
    @(negedge clk);
    reset_n = 1;
    keys(1, 3, 2, 4);
    chk("rst_code_restored", unlock, 1);
    idle(OPEN_CYC);
    for (int i = 0; i < 3; i++) begin
      keys(1, 1, 1, 1);
      if (i < 2) idle(ERR_CYC);
    end
    chk("lock2_locked_out", locked_out, 1);
    idle(5);
    #3 reset_n = 0;
    #1 chk("rst_lock_locked_out", locked_out, 0);
    chk("rst_lock_red", red, 0);
    chk("rst_lock_fail_cnt", fail_cnt, 0);
    @(negedge clk);
    reset_n = 1;

    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        #2 reset_n = 0;
        @(negedge clk);
        reset_n = 1;
      end else if (r < 25) begin
        idle(TIMEOUT_CYC + 1);
      end else begin
        kv = ($urandom_range(0, 99) < 40);
        pr = ($urandom_range(0, 99) < 6);
        if ($urandom_range(0, 99) < 70) begin
          pos = (m == M_ENTRY) ? entered.size() : 0;
          k = mcode[pos];
        end else begin
          k = $urandom_range(0, 15);
        end
        step(kv, k, pr);
      end
    end
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
